ascon_cmd_sequencer: RTL and testbench

Instruction-stream controller that sequences the masked Ascon core (`ascon_core_sca`). It accepts a stream of header-tagged 32-bit instruction words (INS) and shared data words (DAT), in the same format as the `tv/` test-vector files. It decodes each instruction and drives the core's key/bdi handshakes, including `bdi_type`, `bdi_eot` and `bdi_eoi`, plus the persistent `decrypt`/`hash` mode bits. It also forwards core output and captures tag-verification results. It sits between a host/FIFO front end and the core, replacing bench-side sequencing in synthesised SCA targets.

---
 rtl/ascon_cmd_sequencer.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_ascon_cmd_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_cmd_sequencer.sv
// ascon_cmd_sequencer
// Decodes a header-tagged instruction/data word stream and drives the key and
// bdi handshakes of the masked Ascon core. Also holds the persistent
// decrypt/hash mode bits, forwards core output and captures tag-check results.
module ascon_cmd_sequencer #(
  parameter int NUM_SHARES = 2,
  parameter int CCW        = 32,
  parameter int CCSW       = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  // instruction / data stream
  input  logic [NUM_SHARES*CCW-1:0]  in_word,
  input  logic                       in_hdr,
  input  logic                       in_valid,
  output logic                       in_ready,
  // key port to the core
  output logic [NUM_SHARES*CCSW-1:0] key,
  output logic                       key_valid,
  input  logic                       key_ready,
  // bdi port to the core
  output logic [NUM_SHARES*CCW-1:0]  bdi,
  output logic                       bdi_valid,
  input  logic                       bdi_ready,
  output logic [3:0]                 bdi_type,
  output logic                       bdi_eot,
  output logic                       bdi_eoi,
  // mode bits
  output logic                       decrypt,
  output logic                       hash,
  // core output
  input  logic [NUM_SHARES*CCW-1:0]  bdo,
  input  logic                       bdo_valid,
  input  logic [3:0]                 bdo_type,
  input  logic                       bdo_eot,
  output logic                       bdo_ready,
  // forwarded output
  output logic [NUM_SHARES*CCW-1:0]  out_word,
  output logic                       out_valid,
  output logic [3:0]                 out_type,
  output logic                       out_eot,
  input  logic                       out_ready,
  // tag verification
  input  logic                       auth,
  input  logic                       auth_valid,
  output logic                       auth_ready,
  output logic                       auth_ok,
  output logic                       auth_done,
  output logic                       err
);

  // The datapath maps one instruction word onto one 32-bit core word per share.
  if (CCW != 32) begin : g_bad_ccw
    $error("ascon_cmd_sequencer: CCW must be 32");
  end
  if (CCSW != CCW) begin : g_bad_ccsw
    $error("ascon_cmd_sequencer: CCSW must equal CCW");
  end

  // Opcodes (instruction bits [31:28])
  localparam logic [3:0] OP_DO_ENC   = 4'h1;
  localparam logic [3:0] OP_DO_DEC   = 4'h2;
  localparam logic [3:0] OP_DO_HASH  = 4'h3;
  localparam logic [3:0] OP_LD_KEY   = 4'h4;
  localparam logic [3:0] OP_LD_NONCE = 4'h5;
  localparam logic [3:0] OP_LD_AD    = 4'h6;
  localparam logic [3:0] OP_LD_PT    = 4'h7;
  localparam logic [3:0] OP_LD_CT    = 4'h8;
  localparam logic [3:0] OP_LD_TAG   = 4'h9;

  // Core data-type codes
  localparam logic [3:0] D_NULL  = 4'h0;
  localparam logic [3:0] D_NONCE = 4'h1;
  localparam logic [3:0] D_AD    = 4'h2;
  localparam logic [3:0] D_PTCT  = 4'h3;
  localparam logic [3:0] D_TAG   = 4'h4;

  localparam logic [NUM_SHARES*CCW-1:0]  ZERO_W = {(NUM_SHARES*CCW){1'b0}};
  localparam logic [NUM_SHARES*CCSW-1:0] ZERO_K = {(NUM_SHARES*CCSW){1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_NULL = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [22:0] cnt_r, cnt_s;
  logic [3:0]  op_r, op_s;
  logic        eoi_flag_r, eoi_flag_s;
  logic        decrypt_r, decrypt_s;
  logic        hash_r, hash_s;
  logic        err_r, err_s;
  logic        auth_ok_r;
  logic        auth_done_r;

  // Instruction fields; only bit 0 of the flag nibble has a meaning.
  logic [3:0]  ins_op_s;
  logic        ins_eoi_s;
  logic [23:0] ins_len_s;
  logic [24:0] ins_words_s;

  logic        ins_xfer_s;
  logic        dat_xfer_s;
  logic        null_xfer_s;

  // Map a load opcode onto the bdi type it produces.
  function automatic logic [3:0] load_type(input logic [3:0] op);
    logic [3:0] t;
    case (op)
      OP_LD_NONCE: t = D_NONCE;
      OP_LD_AD:    t = D_AD;
      OP_LD_PT:    t = D_PTCT;
      OP_LD_CT:    t = D_PTCT;
      OP_LD_TAG:   t = D_TAG;
      default:     t = D_NULL;
    endcase
    return t;
  endfunction

  assign ins_op_s    = in_word[31:28];
  assign ins_eoi_s   = in_word[24];
  assign ins_len_s   = in_word[23:0];
  // Byte length rounded up to whole words; 25 bits so the +3 cannot wrap.
  assign ins_words_s = ({1'b0, ins_len_s} + 25'd3) >> 2'd2;

  assign ins_xfer_s  = in_valid & in_ready & in_hdr;
  assign dat_xfer_s  = in_valid & in_ready & ~in_hdr;
  assign null_xfer_s = (state_r == ST_NULL) & bdi_ready;

  // Core-facing handshake and data drive, decided by the current state.
  always_comb begin
    in_ready  = 1'b0;
    key       = ZERO_K;
    key_valid = 1'b0;
    bdi       = ZERO_W;
    bdi_valid = 1'b0;
    bdi_type  = D_NULL;
    bdi_eot   = 1'b0;
    bdi_eoi   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        in_ready = 1'b1;
      end
      ST_DATA: begin
        if (in_hdr) begin
          // A new instruction always wins over the pending load.
          in_ready = 1'b1;
        end else if (op_r == OP_LD_KEY) begin
          key       = in_word;
          key_valid = in_valid;
          in_ready  = key_ready;
        end else begin
          bdi       = in_word;
          bdi_valid = in_valid;
          bdi_type  = load_type(op_r);
          bdi_eot   = (cnt_r == 23'd1);
          bdi_eoi   = (cnt_r == 23'd1) & eoi_flag_r;
          in_ready  = bdi_ready;
        end
      end
      ST_NULL: begin
        bdi_valid = 1'b1;
        bdi_type  = D_NULL;
        bdi_eot   = 1'b1;
        bdi_eoi   = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Next-state, word counter, mode bits and error flag.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    op_s       = op_r;
    eoi_flag_s = eoi_flag_r;
    decrypt_s  = decrypt_r;
    hash_s     = hash_r;
    err_s      = err_r;
    if (ins_xfer_s) begin
      // An instruction inside a load truncates it.
      if (state_r == ST_DATA) begin
        err_s = 1'b1;
      end else begin
        err_s = err_r;
      end
      case (ins_op_s)
        OP_DO_ENC: begin
          decrypt_s = 1'b0;
          hash_s    = 1'b0;
          cnt_s     = 23'd0;
          state_s   = ST_IDLE;
        end
        OP_DO_DEC: begin
          decrypt_s = 1'b1;
          hash_s    = 1'b0;
          cnt_s     = 23'd0;
          state_s   = ST_IDLE;
        end
        OP_DO_HASH: begin
          decrypt_s = 1'b0;
          hash_s    = 1'b1;
          cnt_s     = 23'd0;
          state_s   = ST_IDLE;
        end
        OP_LD_KEY, OP_LD_NONCE, OP_LD_AD, OP_LD_PT, OP_LD_CT, OP_LD_TAG: begin
          op_s       = ins_op_s;
          eoi_flag_s = ins_eoi_s;
          cnt_s      = ins_words_s[22:0];
          if (ins_words_s != 25'd0) begin
            state_s = ST_DATA;
          end else if (ins_eoi_s) begin
            state_s = ST_NULL;
          end else begin
            state_s = ST_IDLE;
          end
        end
        default: begin
          err_s   = 1'b1;
          cnt_s   = 23'd0;
          state_s = ST_IDLE;
        end
      endcase
    end else if (dat_xfer_s) begin
      if (state_r == ST_DATA) begin
        cnt_s = cnt_r - 23'd1;
        if (cnt_r == 23'd1) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DATA;
        end
      end else begin
        // Data with no load in progress is dropped.
        err_s = 1'b1;
      end
    end else if (null_xfer_s) begin
      state_s = ST_IDLE;
    end else begin
      state_s = state_r;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 23'd0;
      op_r       <= 4'h0;
      eoi_flag_r <= 1'b0;
      decrypt_r  <= 1'b0;
      hash_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      op_r       <= op_s;
      eoi_flag_r <= eoi_flag_s;
      decrypt_r  <= decrypt_s;
      hash_r     <= hash_s;
      err_r      <= err_s;
    end
  end

  // Capture each tag-check result and pulse auth_done for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      auth_ok_r   <= 1'b0;
      auth_done_r <= 1'b0;
    end else begin
      auth_done_r <= auth_valid;
      if (auth_valid) begin
        auth_ok_r <= auth;
      end else begin
        auth_ok_r <= auth_ok_r;
      end
    end
  end

  assign decrypt    = decrypt_r;
  assign hash       = hash_r;
  assign err        = err_r;
  assign auth_ok    = auth_ok_r;
  assign auth_done  = auth_done_r;
  assign auth_ready = 1'b1;

  // Core output goes straight through to the host side.
  assign out_word  = bdo;
  assign out_valid = bdo_valid;
  assign out_type  = bdo_type;
  assign out_eot   = bdo_eot;
  assign bdo_ready = out_ready;

endmodule

// File: tb/tb_ascon_cmd_sequencer.sv
// Scoreboard bench for ascon_cmd_sequencer: stimulus pushes expected core
// beats into queues, a negedge monitor pops and compares on each handshake.
module tb_ascon_cmd_sequencer;

  localparam logic [3:0] OP_DO_DEC   = 4'h2;
  localparam logic [3:0] OP_DO_HASH  = 4'h3;
  localparam logic [3:0] OP_LD_KEY   = 4'h4;
  localparam logic [3:0] OP_LD_NONCE = 4'h5;
  localparam logic [3:0] OP_LD_AD    = 4'h6;
  localparam logic [3:0] OP_LD_PT    = 4'h7;
  localparam logic [3:0] OP_LD_CT    = 4'h8;
  localparam logic [3:0] OP_LD_TAG   = 4'h9;
  localparam logic [3:0] D_NULL  = 4'h0;
  localparam logic [3:0] D_NONCE = 4'h1;
  localparam logic [3:0] D_AD    = 4'h2;
  localparam logic [3:0] D_PTCT  = 4'h3;
  localparam logic [3:0] D_TAG   = 4'h4;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_word;
  logic        in_hdr, in_valid, in_ready;
  logic [63:0] key;
  logic        key_valid, key_ready;
  logic [63:0] bdi;
  logic        bdi_valid, bdi_ready;
  logic [3:0]  bdi_type;
  logic        bdi_eot, bdi_eoi, decrypt, hash;
  logic [63:0] bdo;
  logic        bdo_valid;
  logic [3:0]  bdo_type;
  logic        bdo_eot, bdo_ready;
  logic [63:0] out_word;
  logic        out_valid;
  logic [3:0]  out_type;
  logic        out_eot, out_ready;
  logic        auth, auth_valid, auth_ready, auth_ok, auth_done, err;

  always #5 clk = ~clk;

  ascon_cmd_sequencer #(.NUM_SHARES(2), .CCW(32), .CCSW(32)) dut (
    .clk(clk), .rst(rst),
    .in_word(in_word), .in_hdr(in_hdr), .in_valid(in_valid), .in_ready(in_ready),
    .key(key), .key_valid(key_valid), .key_ready(key_ready),
    .bdi(bdi), .bdi_valid(bdi_valid), .bdi_ready(bdi_ready),
    .bdi_type(bdi_type), .bdi_eot(bdi_eot), .bdi_eoi(bdi_eoi),
    .decrypt(decrypt), .hash(hash),
    .bdo(bdo), .bdo_valid(bdo_valid), .bdo_type(bdo_type), .bdo_eot(bdo_eot),
    .bdo_ready(bdo_ready),
    .out_word(out_word), .out_valid(out_valid), .out_type(out_type),
    .out_eot(out_eot), .out_ready(out_ready),
    .auth(auth), .auth_valid(auth_valid), .auth_ready(auth_ready),
    .auth_ok(auth_ok), .auth_done(auth_done), .err(err)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [3:0]  t;
    logic        eot;
    logic        eoi;
  } beat_t;

  beat_t       bq[$];
  logic [63:0] kq[$];
  logic        aq[$];
  int          kcyc[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  beat_t       mb;
  logic [63:0] mk;
  logic        ma;
  logic [63:0] w;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event seen, none expected", name);
  endtask

  // Monitor: compare every core-side transfer against the scoreboard.
  always @(negedge clk) begin
    if (key_valid === 1'b1 && key_ready === 1'b1) begin
      if (kq.size() == 0) fail_now("key_unexpected");
      else begin
        mk = kq.pop_front();
        check("key_data", key, mk);
        kcyc.push_back(cyc);
      end
    end
    if (bdi_valid === 1'b1 && bdi_ready === 1'b1) begin
      if (bq.size() == 0) fail_now("bdi_unexpected");
      else begin
        mb = bq.pop_front();
        check("bdi_data", bdi, mb.d);
        check("bdi_type", 64'(bdi_type), 64'(mb.t));
        check("bdi_eot", 64'(bdi_eot), 64'(mb.eot));
        check("bdi_eoi", 64'(bdi_eoi), 64'(mb.eoi));
      end
    end else if (bdi_valid === 1'b1 && bq.size() > 0) begin
      check("bdi_hold", bdi, bq[0].d);
    end
    if (auth_done === 1'b1) begin
      if (aq.size() == 0) fail_now("auth_unexpected");
      else begin
        ma = aq.pop_front();
        check("auth_ok", 64'(auth_ok), 64'(ma));
      end
    end
  end

  function automatic logic [63:0] ins(input logic [3:0] op, input logic [3:0] fl,
                                      input logic [23:0] len);
    return {32'h0000_0000, op, fl, len};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a word and hold it until it is accepted (bounded); in_valid stays up.
  task automatic send(input logic hdr, input logic [63:0] wd);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_hdr   = hdr;
    in_word  = wd;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) fail_now("send_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_hdr   = 1'b0;
    in_word  = 64'h0;
  endtask

  task automatic push_bdi(input logic [63:0] d, input logic [3:0] t,
                          input logic eot, input logic eoi);
    beat_t b;
    b.d = d; b.t = t; b.eot = eot; b.eoi = eoi;
    bq.push_back(b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_word = 64'h0; in_hdr = 1'b0; in_valid = 1'b0;
    key_ready = 1'b1; bdi_ready = 1'b1;
    bdo = 64'h0; bdo_valid = 1'b0; bdo_type = 4'h0; bdo_eot = 1'b0; out_ready = 1'b0;
    auth = 1'b0; auth_valid = 1'b0;
    tick(2);
    // reset state
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_key_valid", 64'(key_valid), 64'd0);
    check("rst_bdi_valid", 64'(bdi_valid), 64'd0);
    check("rst_mode", 64'({decrypt, hash}), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_auth", 64'({auth_ok, auth_done}), 64'd0);
    check("rst_auth_ready", 64'(auth_ready), 64'd1);
    rst = 1'b0;
    tick(1);

    // key load: 4 beats back to back
    send(1'b1, ins(OP_LD_KEY, 4'h0, 24'd16));
    for (int i = 0; i < 4; i++) begin
      w = 64'h1111_2222_3333_0000 + 64'(i);
      kq.push_back(w);
      send(1'b0, w);
    end
    idle();
    tick(1);
    check("key_beats", 64'(kcyc.size()), 64'd4);
    if (kcyc.size() == 4) check("key_consecutive", 64'(kcyc[3] - kcyc[0]), 64'd3);
    check("key_idle", 64'(in_ready), 64'd1);

    // AD len=5 flags=1: two beats, eot/eoi only on the last
    send(1'b1, ins(OP_LD_AD, 4'h1, 24'd5));
    push_bdi(64'hAD00_0000_0000_0001, D_AD, 1'b0, 1'b0);
    send(1'b0, 64'hAD00_0000_0000_0001);
    push_bdi(64'hAD00_0000_0000_0002, D_AD, 1'b1, 1'b1);
    send(1'b0, 64'hAD00_0000_0000_0002);
    idle();
    tick(1);

    // PT len=12 with a 3-cycle stall on word 2
    send(1'b1, ins(OP_LD_PT, 4'h0, 24'd12));
    push_bdi(64'hBB00_0000_0000_0001, D_PTCT, 1'b0, 1'b0);
    send(1'b0, 64'hBB00_0000_0000_0001);
    bdi_ready = 1'b0;
    push_bdi(64'hBB00_0000_0000_0002, D_PTCT, 1'b0, 1'b0);
    fork
      send(1'b0, 64'hBB00_0000_0000_0002);
      begin
        tick(3);
        bdi_ready = 1'b1;
      end
    join
    push_bdi(64'hBB00_0000_0000_0003, D_PTCT, 1'b1, 1'b0);
    send(1'b0, 64'hBB00_0000_0000_0003);
    idle();
    tick(1);
    check("pt_drained", 64'(bq.size()), 64'd0);

    // PT len=0 flags=1: one null beat, input not consumed
    push_bdi(64'h0, D_NULL, 1'b1, 1'b1);
    send(1'b1, ins(OP_LD_PT, 4'h1, 24'd0));
    in_hdr  = 1'b0;
    in_word = 64'hDEAD_BEEF_0000_0000;
    @(negedge clk);
    check("null_in_ready", 64'(in_ready), 64'd0);
    idle();
    tick(1);
    // PT len=0 flags=0: no beat at all
    send(1'b1, ins(OP_LD_PT, 4'h0, 24'd0));
    idle();
    tick(2);
    check("null_drained", 64'(bq.size()), 64'd0);
    check("no_err_yet", 64'(err), 64'd0);

    // mode bits
    send(1'b1, ins(OP_DO_DEC, 4'h0, 24'd0));
    idle();
    check("mode_dec", 64'({decrypt, hash}), 64'b10);
    send(1'b1, ins(OP_DO_HASH, 4'h0, 24'd0));
    idle();
    check("mode_hash", 64'({decrypt, hash}), 64'b01);
    // DAT in IDLE
    send(1'b0, 64'h0BAD_0BAD_0BAD_0BAD);
    idle();
    check("err_dat_idle", 64'(err), 64'd1);
    tick(2);
    check("err_sticky", 64'(err), 64'd1);

    // auth capture
    auth = 1'b1; auth_valid = 1'b1;
    aq.push_back(1'b1);
    tick(1);
    auth = 1'b0; auth_valid = 1'b0;
    tick(1);
    check("auth_done_pulse", 64'(auth_done), 64'd0);
    check("auth_ok_held", 64'(auth_ok), 64'd1);

    // output passthrough
    bdo = 64'hCAFE_F00D_1234_5678; bdo_valid = 1'b1; bdo_type = 4'h3; bdo_eot = 1'b1;
    out_ready = 1'b1;
    #1;
    check("out_word", out_word, 64'hCAFE_F00D_1234_5678);
    check("out_ctl", 64'({out_valid, out_type, out_eot}), 64'b1_0011_1);
    check("bdo_ready_1", 64'(bdo_ready), 64'd1);
    out_ready = 1'b0;
    #1;
    check("bdo_ready_0", 64'(bdo_ready), 64'd0);
    bdo_valid = 1'b0;

    // reset in the middle of a 32-byte AD load
    tick(1);
    send(1'b1, ins(OP_LD_AD, 4'h1, 24'd32));
    for (int i = 0; i < 3; i++) begin
      w = 64'hCC00_0000_0000_0000 + 64'(i);
      push_bdi(w, D_AD, 1'b0, 1'b0);
      send(1'b0, w);
    end
    in_word = 64'hCC00_0000_0000_0003;
    rst = 1'b1;
    #1;
    check("rstmid_bdi_valid", 64'(bdi_valid), 64'd0);
    check("rstmid_key_valid", 64'(key_valid), 64'd0);
    check("rstmid_in_ready", 64'(in_ready), 64'd1);
    check("rstmid_regs", 64'({decrypt, hash, err, auth_ok, auth_done}), 64'd0);
    idle();
    tick(1);
    rst = 1'b0;
    tick(1);
    send(1'b1, ins(OP_LD_NONCE, 4'h1, 24'd4));
    push_bdi(64'hEE00_0000_0000_0001, D_NONCE, 1'b1, 1'b1);
    send(1'b0, 64'hEE00_0000_0000_0001);
    idle();
    tick(1);
    check("post_rst_err", 64'(err), 64'd0);

    // instruction inside a load truncates it and flags an error
    send(1'b1, ins(OP_LD_AD, 4'h1, 24'd8));
    push_bdi(64'hAA00_0000_0000_0001, D_AD, 1'b0, 1'b0);
    send(1'b0, 64'hAA00_0000_0000_0001);
    send(1'b1, ins(OP_LD_TAG, 4'h0, 24'd4));
    push_bdi(64'h7A90_0000_0000_0001, D_TAG, 1'b1, 1'b0);
    send(1'b0, 64'h7A90_0000_0000_0001);
    idle();
    tick(1);
    check("trunc_err", 64'(err), 64'd1);
    send(1'b1, ins(OP_LD_CT, 4'h1, 24'd4));
    push_bdi(64'hC700_0000_0000_0001, D_PTCT, 1'b1, 1'b1);
    send(1'b0, 64'hC700_0000_0000_0001);
    idle();
    tick(1);

    // unknown opcode
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    send(1'b1, ins(4'hF, 4'h0, 24'd0));
    idle();
    check("unknown_op_err", 64'(err), 64'd1);
    check("unknown_op_idle", 64'(in_ready), 64'd1);

    tick(2);
    check("bq_empty", 64'(bq.size()), 64'd0);
    check("kq_empty", 64'(kq.size()), 64'd0);
    check("aq_empty", 64'(aq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
